// File: rtl/fetch_queue.sv
// Instruction fetch queue: a circular buffer of {pc, inst} entries between fetch and decode.
// A redirect (flush) empties it and keeps a running total of the entries it threw away.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_pc,
    input  logic [AW-1:0]          in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_pc,
    output logic [AW-1:0]          out_inst,
    output logic [AW-1:0]          out_snpc,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [31:0]            flush_drops
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [AW-1:0] inst_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [31:0]   drops_q;
    logic          push;
    logic          pop;

    // Handshake flags come from registered occupancy only, so there is no
    // combinational path from the consumer back to the producer.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            drops_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            drops_q <= drops_q + 32'(count_q);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Head outputs read as zero when empty so stale storage never leaks out.
    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (out_valid) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end
    end

    assign out_snpc    = out_pc + AW'(4);
    assign count       = count_q;
    assign flush_drops = drops_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_pc;
    logic [AW-1:0] in_inst;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_inst;
    logic [AW-1:0] out_snpc;
    logic          flush;
    logic [2:0]    count;
    logic [31:0]   flush_drops;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO of {pc, inst} and the running drop total.
    logic [63:0] mq[$];
    logic [31:0] m_drops;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_snpc(out_snpc),
        .flush(flush), .count(count), .flush_drops(flush_drops)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Checks all outputs against the model, drives one cycle, then advances the model.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic ordy, input logic fl, input logic rs);
        logic        push_m;
        logic        pop_m;
        logic [31:0] hpc;
        logic [31:0] hinst;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        hpc   = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
        hinst = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
        checkOutput("count",       32'(count),       32'(mq.size()));
        checkOutput("in_ready",    32'(in_ready),    32'(mq.size() != DEPTH));
        checkOutput("out_valid",   32'(out_valid),   32'(mq.size() != 0));
        checkOutput("out_pc",      out_pc,           hpc);
        checkOutput("out_inst",    out_inst,         hinst);
        checkOutput("out_snpc",    out_snpc,         hpc + 32'd4);
        checkOutput("flush_drops", flush_drops,      m_drops);
        push_m = v && (mq.size() != DEPTH) && !fl;
        pop_m  = (mq.size() != 0) && ordy && !fl;
        @(posedge clk);
        #1;
        if (!rs) begin
            mq.delete();
            m_drops = 32'h0;
        end else if (fl) begin
            m_drops = m_drops + 32'(mq.size());
            mq.delete();
        end else begin
            if (pop_m) mq.delete(0);
            if (push_m) mq.push_back({pc, inst});
        end
    endtask

    initial begin
        logic [31:0] drops_before;
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        m_drops = 32'h0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_pc", out_pc, 32'h0);

        // Fill to full, then offer a fifth entry that must be refused.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h8000_0000 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0010, 32'hBAD, 1'b0, 1'b0, 1'b1);
        checkOutput("fill_count", 32'(count), 32'd4);
        checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
        checkOutput("fill_head", out_pc, 32'h8000_0000);
        checkOutput("fill_snpc", out_snpc, 32'h8000_0004);

        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_pc", out_pc, 32'h8000_0000 + 32'(4 * i));
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("drain_empty", 32'(out_valid), 32'd0);
        checkOutput("drain_pc0", out_pc, 32'h0);

        // Streaming at occupancy one across pointer wrap.
        applyStimulus(1'b1, 32'h1000, 32'h1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stream_pc", out_pc, 32'h1000 + 32'(4 * i));
            checkOutput("stream_count", 32'(count), 32'd1);
            applyStimulus(1'b1, 32'h1004 + 32'(4 * i), 32'h2 + 32'(i), 1'b1, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Flush with three entries and a simultaneous offer.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h2000 + 32'(4 * i), 32'h3, 1'b0, 1'b0, 1'b1);
        drops_before = flush_drops;
        applyStimulus(1'b1, 32'h2FFC, 32'h4, 1'b0, 1'b1, 1'b1);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_drops3", flush_drops, drops_before + 32'd3);

        // Reset beats flush with two entries queued.
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 32'h3000 + 32'(4 * i), 32'h5, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h3008, 32'h6, 1'b1, 1'b1, 1'b0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_drops", flush_drops, 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h7, 1'b0, 1'b0, 1'b1);
        checkOutput("wrap_pc", out_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_snpc", out_snpc, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 24) == 0),
                          1'($urandom_range(0, 199) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
